spm_arbiter: RTL
================

Name: spm_arbiter

Overview:
- Shares one `single_port_mem` instance between NUM_REQ requesters.
- Grants one access per cycle using round-robin arbitration.
- Returns read data tagged with the requester ID.
- Optionally zero-fills the memory after reset, before any requester is served.
- Sits between the vOW engine front-ends and a shared M20K-backed table.

Parameters:
- NUM_REQ, 2: number of requesters (≥2).
- WIDTH, 8: data word width.
- DEPTH, 64: memory depth in words. AW = `CLOG2(DEPTH)`.
- CLEAR_ON_RESET, 1: 1 means run the zero-fill sequence after reset; 0 means go straight to service.
- IDW, derived: `CLOG2(NUM_REQ)`, minimum 1.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_wr  in  NUM_REQ  per-requester op: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- req_data  in  NUM_REQ*WIDTH  flattened write data; requester i uses bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when valid & ready in the same cycle.
- rsp_valid  out  1  read data valid.
- rsp_id  out  IDW  requester index owning rsp_data.
- rsp_data  out  WIDTH  read data, taken directly from the memory q output.
- init_done  out  1  high once the block is serving requests.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state <= CLEAR if CLEAR_ON_RESET, else RUN.
  - clr_cnt <= 0; last_grant <= NUM_REQ-1, so requester 0 has top priority first.
  - rsp_valid <= 0, rsp_id <= 0.
  - init_done <= 0 if CLEAR_ON_RESET, else 1.
  - rsp_data is not reset; it is don't-care while rsp_valid=0.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Memory driven with wr_en=1, address=clr_cnt, data=0. clr_cnt increments each cycle.
  - When clr_cnt==DEPTH-1: the write completes, state <= RUN, init_done <= 1, so init_done rises exactly DEPTH cycles after reset release.
  - req_ready=0 throughout; requests are held, not dropped.
  - Reset mid-CLEAR restarts at address 0.
- RUN arbitration (combinational within the cycle):
  - Search order starts at (last_grant+1) mod NUM_REQ and wraps.
  - The first requester with req_valid=1 gets req_ready=1; all others get 0.
  - With no valid requests, req_ready is all 0 and the memory gets wr_en=0.
  - last_grant updates only on a grant.
  - Continuous contention yields strict rotation; no starvation.
- Memory drive (granted requester g): address=req_addr[g], data=req_data[g], wr_en=req_wr[g].
- Read latency is fixed at 1 cycle:
  - A read granted at cycle t gives rsp_valid=1, rsp_id=g and rsp_data=mem[addr] at cycle t+1.
  - Back-to-back reads produce back-to-back responses.
  - No backpressure on rsp; consumers must accept every cycle.
- Write:
  - Produces no response; rsp_valid=0 the following cycle.
  - A read granted the cycle after a write to the same address returns the new data.
- Single-port hazard: only one access per cycle, so a read and a write are never issued in the same cycle.
- Reset with a read in flight: rsp_valid=0 on the next cycle; the response is lost.
- req_* inputs are ignored whenever req_ready is low; requesters hold stable until accepted.

Decomposition:
- Shared package (vow_mem_pkg): operation encoding constants (OP_READ=0, OP_WRITE=1) and FSM state encodings (ST_CLEAR, ST_RUN).
- Sub-module: single_port_mem, instantiated unchanged with INIT=0 and FILE="".
- Round-robin selection as a function or small combinational block (rr_pick) inside spm_arbiter. No separate module.

Test Plan:
All scenarios use NUM_REQ=2, WIDTH=8, DEPTH=16.
1. CLEAR_ON_RESET=1, pulse rst_n low for 2 cycles → req_ready=0 for 16 cycles, init_done=1 on the 16th edge after release; then req1 reads addr 5 → rsp_valid next cycle, rsp_id=1, rsp_data=0x00.
2. req0 writes 0xA5 to addr 3; next cycle req1 reads addr 3 → rsp_valid=1, rsp_id=1, rsp_data=0xA5 one cycle after the grant; no rsp after the write.
3. After reset, both requesters hold valid reads every cycle (req0 addr 1, req1 addr 2) → grant sequence 0,1,0,1…; rsp_id alternates 0,1 with a continuous rsp_valid.
4. Only req1 valid for 4 cycles, then req0 also valid → req1 granted for 4 consecutive cycles; the next grant goes to req0.
5. rst_n asserted at CLEAR cycle 7, released 1 cycle later → init_done rises 16 cycles after release. Also assert reset the cycle after a read grant → rsp_valid=0.
6. CLEAR_ON_RESET=0 → init_done=1 and req_ready grants on the first cycle after reset release.

Source files
------------

// File: rtl/vow_mem_pkg.sv
// Shared encodings for the vOW memory-sharing blocks: operation codes and arbiter FSM states.
package vow_mem_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } arb_state_e;

endpackage

// File: rtl/single_port_mem.sv
// Single-port synchronous RAM with a registered read port, shaped to map onto one M20K.
module single_port_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned INIT  = 0,
  parameter              FILE  = "",
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    address,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No preload path in this build; contents are established by the owner (e.g. a clear sweep).
  if ((INIT != 0) || (FILE != "")) begin : g_preload_unsupported
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

endmodule

// File: rtl/spm_arbiter.sv
// Round-robin arbiter sharing one single_port_mem between NUM_REQ requesters, with an
// optional zero-fill sweep after reset and 1-cycle read responses tagged by requester.
module spm_arbiter
  import vow_mem_pkg::*;
#(
  parameter int unsigned  NUM_REQ        = 2,
  parameter int unsigned  WIDTH          = 8,
  parameter int unsigned  DEPTH          = 64,
  parameter int unsigned  CLEAR_ON_RESET = 1,
  localparam int unsigned AW             = $clog2(DEPTH),
  localparam int unsigned IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_wr,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     init_done
);

  arb_state_e       state_q, state_d;
  logic [AW-1:0]    clr_cnt_q;
  logic [IDW-1:0]   last_grant_q;
  logic [IDW-1:0]   grant_id;
  logic             grant;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             init_done_q;
  logic             mem_wr_en;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data;

  // Nearest valid requester after `last` wins; scanning far-to-near lets the nearest overwrite.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     last);
    logic [IDW-1:0] pick;
    int             idx;
    pick = last;
    for (int k = int'(NUM_REQ); k > 0; k--) begin
      idx = (int'(last) + k) % int'(NUM_REQ);
      if (valid[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_id  = rr_pick(req_valid, last_grant_q);
    grant     = 1'b0;
    req_ready = '0;
    mem_wr_en = 1'b0;
    mem_addr  = clr_cnt_q;
    mem_data  = '0;
    unique case (state_q)
      ST_CLEAR: begin
        mem_wr_en = 1'b1;
        if (clr_cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (|req_valid) begin
          grant               = 1'b1;
          req_ready[grant_id] = 1'b1;
          mem_wr_en           = req_wr[grant_id];
          mem_addr            = req_addr[grant_id*AW +: AW];
          mem_data            = req_data[grant_id*WIDTH +: WIDTH];
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q    <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      init_done_q  <= (CLEAR_ON_RESET == 0);
    end else begin
      state_q     <= state_d;
      init_done_q <= (state_d == ST_RUN);
      rsp_valid_q <= grant && (req_wr[grant_id] == OP_READ);
      if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
      if (grant) begin
        last_grant_q <= grant_id;
        rsp_id_q     <= grant_id;
      end
    end
  end

  single_port_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .INIT  (0),
    .FILE  ("")
  ) u_mem (
    .clock   (clock),
    .wr_en   (mem_wr_en),
    .address (mem_addr),
    .data    (mem_data),
    .q       (rsp_data)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign init_done = init_done_q;

endmodule
